spis_word_rx: RTL and testbench
===============================

Name: spis_word_rx

Overview:
- Front-end stage of the SPI slave receive path. Synchronises the raw SCK/MOSI/CS pins into the system clock domain and assembles 32-bit words, LSB-first.
- Feeds the DMA write FIFO through a single-cycle strobe, with backpressure taken from the FIFO's full flag.
- At end of transaction it pads to an even word count, since the DMA cannot write a single word. It then issues the flush and waits for the FIFO's finished signal before accepting a new transaction.

Parameters:
SYNC_STAGES, 2, synchroniser flops per pin before edge-detect history flop (min 2)
PAD_EVEN, 1, 1 = pad odd word counts to even at CS release
PAD_WORD, 32'h00000000, value emitted as the pad word

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  block enable; low forces IDLE
clear_status  in  1  single-cycle pulse, clears sticky status bits
SCK  in  1  raw SPI clock pin
MOSI  in  1  raw SPI data pin
CS  in  1  raw SPI chip select pin, active low
word_data  out  32  assembled word to FIFO
word_strobe  out  1  one-cycle write strobe to FIFO
fifo_full  in  1  FIFO full flag
flush  out  1  one-cycle flush request to FIFO
fifo_finished  in  1  FIFO flush complete
words_received  out  32  real words accepted this transaction (pads excluded)
pad_added  out  1  pad word issued this transaction
overflow  out  1  sticky: word dropped, or CS fall ignored while busy
partial  out  1  sticky: CS released with 1-31 bits pending
in_transaction  out  1  high from CS fall until finished seen

Behaviour:
- Reset (async): all outputs 0, state IDLE, bit_cnt 0, shift register 0, synchroniser flops 1 for CS, 0 for SCK and MOSI.
- Synchronisation:
  - Each pin passes through SYNC_STAGES flops plus one history flop.
  - sck_rise = sync high & hist low. cs_fall and cs_rise are defined likewise on CS.
  - Pin-to-detect latency is SYNC_STAGES+1 clk cycles.
- States:
  - IDLE:
    - cs_fall & enable -> RECV. Clear bit_cnt, words_received and pad_added; set in_transaction=1.
    - cs_fall while not IDLE -> ignored, overflow=1.
  - RECV:
    - On sck_rise with synchronised CS low: shreg <= {mosi_sync, shreg[31:1]}; bit_cnt++.
    - A rise coinciding with synchronised CS high is ignored.
    - When the 32nd bit arrives (bit_cnt==31): the next cycle drives word_data={mosi_sync, shreg[31:1]} and word_strobe=1 for exactly one cycle, and words_received increments, provided fifo_full is low in the completion cycle.
    - If fifo_full is high in the completion cycle: word dropped, no strobe, overflow=1, count unchanged.
    - bit_cnt wraps to 0 in either case.
    - On cs_rise: if bit_cnt!=0, set partial=1 and discard the bits. Then, if PAD_EVEN & words_received[0], go to PAD; otherwise go to FLUSH.
  - PAD: wait while fifo_full. When not full, emit PAD_WORD with a one-cycle strobe, set pad_added=1, go to FLUSH.
  - FLUSH: flush=1 for exactly one cycle -> WAIT_DONE.
  - WAIT_DONE: on fifo_finished=1 -> IDLE, in_transaction=0. The IDLE transition takes one cycle; cs_fall detected in that same cycle is ignored and sets overflow.
- Strobe spacing: word_strobe is never high on consecutive cycles. A minimum of 32 SCK edges separates real words.
- enable low, any state: next cycle go to IDLE. word_strobe, flush and in_transaction go to 0. No flush is issued and bit_cnt is cleared. words_received and the sticky bits hold.
- clear_status clears overflow and partial. If it coincides with a set event, set wins.
- words_received wraps modulo 2^32. Bit order is LSB-first: first SCK bit lands in word_data[0].

Test Plan:
- Enable, CS low, clock 64 bits (word0 32'hA5A5_0001, word1 32'h1234_5678, LSB-first), CS high -> two strobes with exact data; words_received=2; pad_added=0; one flush pulse; in_transaction drops one cycle after fifo_finished.
- 96 bits (3 words) with PAD_EVEN=1 -> 4 strobes, last carrying 32'h0; words_received=3; pad_added=1; flush after pad strobe.
- Hold fifo_full=1 during completion of word 2 of 4 -> 3 strobes, overflow=1, words_received=3. A PAD is issued because 3 is odd. With fifo_full held during PAD, pad strobe waits until full deasserts.
- 40 bits then CS high -> 1 word strobed, partial=1, pad issued. clear_status pulse -> partial=0, overflow=0.
- Drop enable mid-word (bit 17) -> state IDLE next cycle, no strobe, no flush. Re-enable with new CS fall -> fresh word assembly from bit 0.
- Assert async reset mid-RECV between clk edges -> all outputs 0 immediately. CS fall during WAIT_DONE -> ignored, overflow=1.

Source files
------------

// File: rtl/spis_word_rx_if.sv
// FIFO-side handshake of the SPI slave word receiver: word write strobe,
// flush request and the FIFO's full/finished flags.
interface spis_word_rx_if;
  logic [31:0] word_data;
  logic        word_strobe;
  logic        fifo_full;
  logic        flush;
  logic        fifo_finished;

  modport master (
    output word_data,
    output word_strobe,
    output flush,
    input  fifo_full,
    input  fifo_finished
  );

  modport slave (
    input  word_data,
    input  word_strobe,
    input  flush,
    output fifo_full,
    output fifo_finished
  );
endinterface

// File: rtl/spis_word_rx.sv
// SPI slave receive front end: synchronises SCK/MOSI/CS, assembles LSB-first
// 32-bit words, pads odd word counts and runs the FIFO flush handshake.
module spis_word_rx #(
  parameter int          SYNC_STAGES = 2,
  parameter bit          PAD_EVEN    = 1'b1,
  parameter logic [31:0] PAD_WORD    = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear_status,
  input  logic               SCK,
  input  logic               MOSI,
  input  logic               CS,
  spis_word_rx_if.master     fifo,
  output logic [31:0]        words_received,
  output logic               pad_added,
  output logic               overflow,
  output logic               partial,
  output logic               in_transaction
);

  typedef enum logic [2:0] {IDLE, RECV, PAD, FLUSH, WAIT_DONE} state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sck_sync_reg, mosi_sync_reg, cs_sync_reg;
  logic                   sck_hist_reg, cs_hist_reg;
  logic                   sck_s, mosi_s, cs_s;
  logic                   sck_rise, cs_fall, cs_rise;

  logic [31:0] shreg_reg;
  logic [4:0]  bit_cnt_reg;
  logic [31:0] word_data_reg;
  logic        word_strobe_reg;
  logic        flush_reg;
  logic [31:0] words_received_reg;
  logic        pad_added_reg, overflow_reg, partial_reg, in_transaction_reg;

  logic start, bit_accept, word_done, pad_go, cs_end, ovf_set, part_set;

  // CS idles high, so its chain resets to 1 to avoid a false fall out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_reg  <= '0;
      mosi_sync_reg <= '0;
      cs_sync_reg   <= '1;
      sck_hist_reg  <= 1'b0;
      cs_hist_reg   <= 1'b1;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], SCK};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], CS};
      sck_hist_reg  <= sck_sync_reg[SYNC_STAGES-1];
      cs_hist_reg   <= cs_sync_reg[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist_reg;
  assign cs_fall  = ~cs_s & cs_hist_reg;
  assign cs_rise  = cs_s & ~cs_hist_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    bit_accept = 1'b0;
    word_done  = 1'b0;
    pad_go     = 1'b0;
    cs_end     = 1'b0;
    ovf_set    = 1'b0;
    part_set   = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      ovf_set = cs_fall && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            state_next = RECV;
            start      = 1'b1;
          end
        end
        RECV: begin
          if (cs_rise) begin
            cs_end     = 1'b1;
            part_set   = (bit_cnt_reg != 5'd0);
            state_next = (PAD_EVEN && words_received_reg[0]) ? PAD : FLUSH;
          end else if (sck_rise && !cs_s) begin
            bit_accept = 1'b1;
            word_done  = (bit_cnt_reg == 5'd31);
            if (word_done && fifo.fifo_full) ovf_set = 1'b1;
          end
        end
        PAD: begin
          if (!fifo.fifo_full) begin
            pad_go     = 1'b1;
            state_next = FLUSH;
          end
        end
        FLUSH:     state_next = WAIT_DONE;
        WAIT_DONE: if (fifo.fifo_finished) state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_reg          <= '0;
      bit_cnt_reg        <= '0;
      word_data_reg      <= '0;
      word_strobe_reg    <= 1'b0;
      flush_reg          <= 1'b0;
      words_received_reg <= '0;
      pad_added_reg      <= 1'b0;
      in_transaction_reg <= 1'b0;
    end else begin
      word_strobe_reg <= 1'b0;
      flush_reg       <= 1'b0;
      if (!enable) begin
        bit_cnt_reg        <= '0;
        in_transaction_reg <= 1'b0;
      end else begin
        if (start) begin
          bit_cnt_reg        <= '0;
          words_received_reg <= '0;
          pad_added_reg      <= 1'b0;
          in_transaction_reg <= 1'b1;
        end
        if (bit_accept) begin
          shreg_reg   <= {mosi_s, shreg_reg[31:1]};
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
        end
        if (word_done && !fifo.fifo_full) begin
          word_data_reg      <= {mosi_s, shreg_reg[31:1]};
          word_strobe_reg    <= 1'b1;
          words_received_reg <= words_received_reg + 32'd1;
        end
        if (cs_end) bit_cnt_reg <= '0;
        if (pad_go) begin
          word_data_reg   <= PAD_WORD;
          word_strobe_reg <= 1'b1;
          pad_added_reg   <= 1'b1;
        end
        // flush lands one cycle after any pad strobe, never alongside it
        if (state_reg == FLUSH) flush_reg <= 1'b1;
        if (state_reg == WAIT_DONE && fifo.fifo_finished) in_transaction_reg <= 1'b0;
      end
    end
  end

  // Sticky status: a set event in the same cycle as clear_status wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
      partial_reg  <= 1'b0;
    end else begin
      if (ovf_set)           overflow_reg <= 1'b1;
      else if (clear_status) overflow_reg <= 1'b0;
      if (part_set)          partial_reg  <= 1'b1;
      else if (clear_status) partial_reg  <= 1'b0;
    end
  end

  assign fifo.word_data   = word_data_reg;
  assign fifo.word_strobe = word_strobe_reg;
  assign fifo.flush       = flush_reg;
  assign words_received   = words_received_reg;
  assign pad_added        = pad_added_reg;
  assign overflow         = overflow_reg;
  assign partial          = partial_reg;
  assign in_transaction   = in_transaction_reg;

endmodule

// File: tb/tb_spis_word_rx.sv
// Directed/randomised bench for spis_word_rx; expected words come from a
// transaction-level model (sent words minus dropped ones, plus an even-count pad).
module tb_spis_word_rx;
  localparam logic [31:0] PAD_W   = 32'h0000_0000;
  localparam bit          PAD_ON  = 1'b1;

  logic        clk = 1'b0;
  logic        reset, enable, clear_status, SCK, MOSI, CS;
  logic [31:0] words_received;
  logic        pad_added, overflow, partial, in_transaction;

  spis_word_rx_if bus();

  spis_word_rx #(.SYNC_STAGES(2), .PAD_EVEN(PAD_ON), .PAD_WORD(PAD_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_status(clear_status),
    .SCK(SCK), .MOSI(MOSI), .CS(CS), .fifo(bus),
    .words_received(words_received), .pad_added(pad_added), .overflow(overflow),
    .partial(partial), .in_transaction(in_transaction)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] tx_words[$];
  int flush_cnt = 0;
  int flush_base = 0;
  int strobes_at_flush = 0;
  int b2b = 0;
  bit prev_strobe = 1'b0;
  int nacc = 0;
  bit exp_pad = 1'b0;

  // Observe FIFO-side activity away from the active edge
  always @(negedge clk) begin
    if (bus.word_strobe) got_q.push_back(bus.word_data);
    if (bus.word_strobe && prev_strobe) b2b++;
    prev_strobe = bus.word_strobe;
    if (bus.flush) begin
      flush_cnt++;
      strobes_at_flush = got_q.size();
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, input bit full);
    MOSI = b;
    repeat (4) @(negedge clk);
    if (full) bus.fifo_full = 1'b1;
    SCK = 1'b1;
    repeat (4) @(negedge clk);
    SCK = 1'b0;
    if (full) bus.fifo_full = 1'b0;
  endtask

  task automatic load_random(input int n);
    tx_words.delete();
    for (int i = 0; i < n; i++) tx_words.push_back($urandom);
  endtask

  task automatic send_txn(input int nextra, input int drop_idx, input bit hold_full);
    logic [31:0] tw;
    got_q.delete();
    exp_q.delete();
    nacc = 0;
    flush_base = flush_cnt;
    CS = 1'b0;
    repeat (6) @(negedge clk);
    for (int w = 0; w < tx_words.size(); w++) begin
      tw = tx_words[w];
      for (int b = 0; b < 32; b++) spi_bit(tw[b], (w == drop_idx) && (b == 31));
      if (w != drop_idx) begin
        exp_q.push_back(tw);
        nacc++;
      end
    end
    for (int e = 0; e < nextra; e++) spi_bit(1'($urandom_range(0, 1)), 1'b0);
    repeat (4) @(negedge clk);
    if (hold_full) bus.fifo_full = 1'b1;
    CS = 1'b1;
    exp_pad = PAD_ON && (nacc % 2 == 1);
    if (exp_pad) exp_q.push_back(PAD_W);
    if (hold_full) begin
      repeat (20) @(negedge clk);
      check("pad_waits_full", got_q.size(), nacc);
      check("no_flush_while_full", flush_cnt, flush_base);
      bus.fifo_full = 1'b0;
    end
  endtask

  task automatic finish_txn(input string tag, input bit cs_poke);
    int t = 0;
    while (flush_cnt == flush_base && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_flush_seen"}, flush_cnt, flush_base + 1);
    check({tag, "_strobes_before_flush"}, strobes_at_flush, exp_q.size());
    check({tag, "_strobe_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_words_received"}, words_received, nacc);
    check({tag, "_pad_added"}, pad_added, exp_pad);
    check({tag, "_in_txn_busy"}, in_transaction, 1'b1);
    check({tag, "_no_b2b_strobe"}, b2b, 0);
    if (cs_poke) begin
      CS = 1'b0;
      repeat (6) @(negedge clk);
      check({tag, "_cs_fall_busy_ovf"}, overflow, 1'b1);
    end
    repeat (2) @(negedge clk);
    bus.fifo_finished = 1'b1;
    @(negedge clk);
    bus.fifo_finished = 1'b0;
    check({tag, "_in_txn_drop"}, in_transaction, 1'b0);
    repeat (4) @(negedge clk);
    check({tag, "_single_flush"}, flush_cnt, flush_base + 1);
    if (cs_poke) begin
      CS = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; enable = 1'b0; clear_status = 1'b0;
    SCK = 1'b0; MOSI = 1'b0; CS = 1'b1;
    bus.fifo_full = 1'b0; bus.fifo_finished = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_words", words_received, 32'd0);
    check("rst_flags", {pad_added, overflow, partial, in_transaction, bus.word_strobe, bus.flush}, 6'd0);
    check("rst_data", bus.word_data, 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clk);

    tx_words.delete();
    tx_words.push_back(32'hA5A5_0001);
    tx_words.push_back(32'h1234_5678);
    send_txn(0, -1, 1'b0);
    finish_txn("two_words", 1'b0);
    check("two_words_ovf", overflow, 1'b0);
    check("two_words_partial", partial, 1'b0);

    load_random(3);
    send_txn(0, -1, 1'b0);
    finish_txn("three_pad", 1'b0);

    load_random(4);
    send_txn(0, 1, 1'b1);
    finish_txn("drop_word", 1'b0);
    check("drop_word_ovf", overflow, 1'b1);

    load_random(1);
    send_txn(8, -1, 1'b0);
    finish_txn("partial40", 1'b0);
    check("partial40_flag", partial, 1'b1);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    check("clr_partial", partial, 1'b0);
    check("clr_overflow", overflow, 1'b0);

    // Disable mid-word after one complete word and 17 bits
    got_q.delete();
    flush_base = flush_cnt;
    r = $urandom;
    CS = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 0; b < 32; b++) spi_bit(r[b], 1'b0);
    for (int b = 0; b < 17; b++) spi_bit(1'($urandom_range(0, 1)), 1'b0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_in_txn", in_transaction, 1'b0);
    repeat (10) @(negedge clk);
    check("dis_no_flush", flush_cnt, flush_base);
    check("dis_strobes", got_q.size(), 1);
    if (got_q.size() > 0) check("dis_word0", got_q[0], r);
    check("dis_words_hold", words_received, 32'd1);
    CS = 1'b1;
    repeat (6) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    load_random(1);
    send_txn(0, -1, 1'b0);
    finish_txn("reenable", 1'b0);

    check("pre_poke_ovf", overflow, 1'b0);
    load_random(2);
    send_txn(0, -1, 1'b0);
    finish_txn("wait_done_poke", 1'b1);

    // Asynchronous reset between clock edges during reception
    CS = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 0; b < 40; b++) spi_bit(1'($urandom_range(0, 1)), 1'b0);
    check("pre_rst_in_txn", in_transaction, 1'b1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_words", words_received, 32'd0);
    check("arst_flags", {pad_added, overflow, partial, in_transaction, bus.word_strobe, bus.flush}, 6'd0);
    check("arst_data", bus.word_data, 32'd0);
    @(negedge clk);
    CS = 1'b1;
    reset = 1'b0;
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
